// File: rtl/adder_pkg.sv
// Shared parameters and elaboration helpers for the pipelined adder.
package adder_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultSlice = 4;

  // Number of pipeline stages; guarded so a bad SLICE reports an error instead of dividing by zero.
  function automatic int unsigned nstage(input int unsigned width, input int unsigned slice);
    return (slice == 0) ? 1 : width / slice;
  endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
interface adder_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/adder_slice.sv
// Combinational ripple-carry adder for one pipeline slice.
module adder_slice #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             ci,
  output logic [Width-1:0] s,
  output logic             co
);
  logic [Width:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < Width; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[Width];
endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder: one SLICE-bit chunk per stage, carry registered between stages,
// single global advance so the whole pipe stalls together under backpressure.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned SLICE = DefaultSlice
) (
  input logic         clk,
  input logic         rst,
  adder_pipe_if.slave bus
);
  localparam int unsigned NSTAGE = nstage(WIDTH, SLICE);
  localparam int unsigned MSB    = WIDTH - 1;
  localparam int unsigned LAST   = NSTAGE - 1;

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("adder_pipe: WIDTH (%0d) must be a multiple of a non-zero SLICE (%0d)", WIDTH, SLICE);
  end

  logic             adv;
  logic             valid_q [NSTAGE];
  logic             carry_q [NSTAGE];
  logic [WIDTH-1:0] sum_q   [NSTAGE];
  logic [WIDTH-1:0] a_q     [NSTAGE];
  logic [WIDTH-1:0] b_q     [NSTAGE];

  assign adv          = !valid_q[LAST] || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic             src_valid;
    logic             src_carry;
    logic [WIDTH-1:0] src_sum;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] sum_nxt;
    logic [SLICE-1:0] slice_s;
    logic             slice_co;

    if (k == 0) begin : g_head
      assign src_valid = bus.in_valid;
      assign src_carry = bus.cin;
      assign src_sum   = '0;
      assign src_a     = bus.a;
      assign src_b     = bus.b;
    end else begin : g_body
      assign src_valid = valid_q[k-1];
      assign src_carry = carry_q[k-1];
      assign src_sum   = sum_q[k-1];
      assign src_a     = a_q[k-1];
      assign src_b     = b_q[k-1];
    end

    adder_slice #(
      .Width(SLICE)
    ) u_slice (
      .a (src_a[k*SLICE +: SLICE]),
      .b (src_b[k*SLICE +: SLICE]),
      .ci(src_carry),
      .s (slice_s),
      .co(slice_co)
    );

    always_comb begin
      sum_nxt                   = src_sum;
      sum_nxt[k*SLICE +: SLICE] = slice_s;
    end

    // Bubbles move with adv like real beats; data only loads for real beats to limit toggling.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end else if (adv) begin
        valid_q[k] <= src_valid;
        if (src_valid) begin
          carry_q[k] <= slice_co;
          sum_q[k]   <= sum_nxt;
          a_q[k]     <= src_a;
          b_q[k]     <= src_b;
        end
      end
    end
  end

  assign bus.out_valid = valid_q[LAST];
  assign bus.s         = sum_q[LAST];
  assign bus.cout      = carry_q[LAST];
  // Operand MSBs travel with the beat so ovf never looks at live inputs.
  assign bus.ovf       = (a_q[LAST][MSB] == b_q[LAST][MSB]) && (sum_q[LAST][MSB] != a_q[LAST][MSB]);

  logic unused_ops;
  assign unused_ops = ^{a_q[LAST], b_q[LAST]};
endmodule
